accum_load_dispatch: RTL and testbench

Upstream feeder for the accumulator processor array, running entirely in the proc_clk domain. It accepts 32-bit load words that have already been synchronized from the bus domain and buffers them in a small FIFO. It deals the words out one at a time to NUM_LANES processor lanes using round-robin order. It counts dispatched words and raises a sticky done flag once a full batch of TOTAL_WORDS has been handed out.

---
 rtl/accum_pkg.sv | 36 +++
 rtl/accum_fifo.sv | 47 ++++
 rtl/accum_load_dispatch.sv | 120 ++++++++++++
 tb/tb_accum_load_dispatch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared constants, offer-state encoding and round-robin lane selection
// for the accumulator load dispatcher.
package accum_pkg;

  localparam int DATA_W      = 32;
  localparam int NUM_LANES   = 4;
  localparam int TOTAL_WORDS = 1024;
  localparam int CNT_W       = 11;
  localparam int LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } offer_state_t;

  // First set bit of rdy found scanning upward from ptr, wrapping; one-hot result.
  function automatic logic [NUM_LANES-1:0] rr_select(
    input logic [NUM_LANES-1:0] rdy,
    input logic [LANE_W-1:0]    ptr
  );
    logic [NUM_LANES-1:0] sel;
    logic                 found;
    int                   idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = (int'(ptr) + k) % NUM_LANES;
      if (!found && rdy[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/accum_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head word is visible
// combinationally so the dispatcher can capture it on the pop edge.
module accum_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              proc_clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  import accum_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only; pointers alone define validity.
  always_ff @(posedge proc_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/accum_load_dispatch.sv
// Buffers synchronized load words and deals them round-robin to the
// processor lanes, counting the batch and flagging completion/overflow.
module accum_load_dispatch #(
  parameter int DATA_W      = accum_pkg::DATA_W,
  parameter int NUM_LANES   = accum_pkg::NUM_LANES,
  parameter int DEPTH       = 16,
  parameter int TOTAL_WORDS = accum_pkg::TOTAL_WORDS,
  parameter int CNT_W       = accum_pkg::CNT_W
) (
  input  logic                 proc_clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [NUM_LANES-1:0] lane_valid,
  output logic [DATA_W-1:0]    lane_data,
  input  logic [NUM_LANES-1:0] lane_ready,
  output logic [CNT_W-1:0]     words_accepted,
  output logic [CNT_W-1:0]     words_dispatched,
  output logic                 done,
  output logic                 overflow
);
  import accum_pkg::*;

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_WORDS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL_WORDS - 1);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_W-1:0]    fifo_head;
  logic                 push;
  logic                 load;
  logic                 hs;
  logic [LANE_W-1:0]    hs_idx;
  logic [LANE_W-1:0]    rr_q;
  logic [LANE_W-1:0]    rr_base;
  logic [NUM_LANES-1:0] target;
  offer_state_t         state_q;
  offer_state_t         state_d;

  assign in_ready = !fifo_full && (words_accepted < TOTAL_C);
  assign push     = in_valid && in_ready;

  accum_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .proc_clk (proc_clk),
    .reset    (reset),
    .push     (push),
    .wr_data  (in_data),
    .pop      (load),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A reload after a handshake must scan from the lane after the one just
  // served, otherwise a continuously ready lane would starve the others.
  always_comb begin
    hs_idx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_valid[i]) hs_idx = LANE_W'(i);
    end
    hs      = (state_q == ST_OFFER) && |(lane_valid & lane_ready);
    rr_base = hs ? LANE_W'((int'(hs_idx) + 1) % NUM_LANES) : rr_q;
    target  = rr_select(lane_ready, rr_base);
    load    = !fifo_empty && |lane_ready && ((state_q == ST_IDLE) || hs);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (load) state_d = ST_OFFER;
      ST_OFFER: if (hs && !load) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Offer register: held stable until its own lane accepts it.
  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      lane_valid <= '0;
      lane_data  <= '0;
      rr_q       <= '0;
    end else begin
      if (hs) rr_q <= rr_base;
      if (load) begin
        lane_valid <= target;
        lane_data  <= fifo_head;
      end else if (hs) begin
        lane_valid <= '0;
      end
    end
  end

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      words_accepted   <= '0;
      words_dispatched <= '0;
      done             <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      if (push && (words_accepted != TOTAL_C))
        words_accepted <= words_accepted + CNT_W'(1);
      if (hs && (words_dispatched != TOTAL_C))
        words_dispatched <= words_dispatched + CNT_W'(1);
      if (hs && (words_dispatched == LAST_C))
        done <= 1'b1;
      if (in_valid && !in_ready)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accum_load_dispatch.sv
// Scoreboard bench for accum_load_dispatch: accepted words queue up as
// expected dispatches; a negedge monitor checks offers, counters and flags.
module tb_accum_load_dispatch;

  localparam int DATA_W = 32;
  localparam int N      = 4;
  localparam int DEPTH  = 16;
  localparam int TOTAL  = 1024;
  localparam int CNT_W  = 11;

  logic              proc_clk = 1'b0;
  logic              reset    = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_ready;
  logic [N-1:0]      lane_valid;
  logic [DATA_W-1:0] lane_data;
  logic [N-1:0]      lane_ready = '0;
  logic [CNT_W-1:0]  words_accepted;
  logic [CNT_W-1:0]  words_dispatched;
  logic              done;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                m_acc, m_disp, m_rr;
  bit                m_ovf;
  longint            sum_push, sum_disp;
  bit                prev_pending;
  logic [N-1:0]      prev_lv, prev_ready;
  logic [DATA_W-1:0] prev_ld;

  accum_load_dispatch #(
    .DATA_W(DATA_W), .NUM_LANES(N), .DEPTH(DEPTH), .TOTAL_WORDS(TOTAL), .CNT_W(CNT_W)
  ) dut (
    .proc_clk(proc_clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .lane_valid(lane_valid), .lane_data(lane_data),
    .lane_ready(lane_ready), .words_accepted(words_accepted),
    .words_dispatched(words_dispatched), .done(done), .overflow(overflow)
  );

  always #5 proc_clk = ~proc_clk;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first ready lane at or after rr, wrapping.
  function automatic int first_ready(input logic [N-1:0] rdy, input int rr);
    for (int k = 0; k < N; k++) begin
      if (rdy[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge proc_clk) begin
    int occ, exp_lane, idx;
    bit m_in_ready, hs;
    logic [DATA_W-1:0] exp_word;
    if (!reset) begin
      check(lane_valid == '0, "rst_lane_valid", lane_valid, 0);
      check(lane_data == '0, "rst_lane_data", lane_data, 0);
      check(words_accepted == '0, "rst_accepted", words_accepted, 0);
      check(words_dispatched == '0, "rst_dispatched", words_dispatched, 0);
      check(!done && !overflow, "rst_flags", {done, overflow}, 0);
      exp_q.delete();
      m_acc = 0; m_disp = 0; m_rr = 0; m_ovf = 0;
      sum_push = 0; sum_disp = 0;
      prev_pending = 0; prev_lv = '0; prev_ld = '0; prev_ready = lane_ready;
    end else begin
      occ = exp_q.size() - ((lane_valid != '0) ? 1 : 0);
      m_in_ready = (occ < DEPTH) && (m_acc < TOTAL);
      check(in_ready == m_in_ready, "in_ready", in_ready, m_in_ready);
      check(int'(words_accepted) == m_acc, "words_accepted", words_accepted, m_acc);
      check(int'(words_dispatched) == m_disp, "words_dispatched", words_dispatched, m_disp);
      check(done == (m_disp == TOTAL), "done", done, (m_disp == TOTAL));
      check(overflow == m_ovf, "overflow", overflow, m_ovf);
      check($countones(lane_valid) <= 1, "onehot", lane_valid, 0);
      if (lane_valid != '0) begin
        if (prev_pending) begin
          check(lane_valid == prev_lv, "offer_hold_lane", lane_valid, prev_lv);
          check(lane_data == prev_ld, "offer_hold_data", lane_data, prev_ld);
        end else begin
          exp_lane = first_ready(prev_ready, m_rr);
          check(exp_lane >= 0 && lane_valid == (N'(1) << exp_lane), "rr_target",
                lane_valid, (exp_lane >= 0) ? (1 << exp_lane) : 0);
        end
      end
      hs = |(lane_valid & lane_ready);
      if (hs) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (lane_valid[i]) idx = i;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_dispatch", lane_data, 0);
        end else begin
          exp_word = exp_q.pop_front();
          check(lane_data == exp_word, "dispatch_data", lane_data, exp_word);
        end
        m_disp++;
        sum_disp += longint'(lane_data);
        m_rr = (idx + 1) % N;
      end
      if (in_valid && m_in_ready) begin
        exp_q.push_back(in_data);
        m_acc++;
        sum_push += longint'(in_data);
      end else if (in_valid) begin
        m_ovf = 1;
      end
      prev_lv      = lane_valid;
      prev_ld      = lane_data;
      prev_pending = (lane_valid != '0) && !hs;
      prev_ready   = lane_ready;
    end
  end

  task automatic tick();
    @(posedge proc_clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0;
    reset    = 0;
    repeat (2) @(posedge proc_clk);
    #1 reset = 1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || lane_valid != '0) && n < budget) begin
      tick();
      n++;
    end
    check(n < budget, "drain_timeout", n, budget);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    int n;

    // Three words to fully ready lanes: order 0,1,2 and one-edge offer latency.
    do_reset();
    check(in_ready == 1'b1, "ready_after_reset", in_ready, 1);
    lane_ready = 4'b1111;
    tick(); in_valid = 1; in_data = 32'h5;
    tick(); check(lane_valid == '0, "latency_early", lane_valid, 0); in_data = 32'h7;
    tick(); check(lane_valid == 4'b0001 && lane_data == 32'h5, "latency_first", lane_valid, 1);
    in_data = 32'h9;
    tick(); in_valid = 0;
    wait_drain(50);
    check(words_dispatched == 3, "three_dispatched", words_dispatched, 3);

    // Fill the FIFO with no ready lane, then one refused word.
    do_reset();
    lane_ready = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      tick(); in_valid = 1; in_data = $urandom;
    end
    tick(); check(in_ready == 1'b0, "full_ready_low", in_ready, 0); in_data = 32'hDEAD_BEEF;
    tick(); in_valid = 0;
    check(overflow == 1'b1, "overflow_set", overflow, 1);
    check(words_accepted == 16, "accepted_16", words_accepted, 16);
    lane_ready = 4'b1111;
    wait_drain(100);
    check(words_dispatched == 16, "dispatched_16", words_dispatched, 16);

    // Pending offer to lane 2 survives other lanes becoming ready.
    do_reset();
    lane_ready = 4'b0100;
    d = $urandom;
    tick(); in_valid = 1; in_data = d;
    tick(); in_valid = 0;
    tick(); check(lane_valid == 4'b0100, "pend_loaded", lane_valid, 4);
    lane_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      tick();
      check(lane_valid == 4'b0100 && lane_data == d, "pend_stable", lane_valid, 4);
    end
    lane_ready = 4'b1111;
    tick(); check(words_dispatched == 1 && lane_valid == '0, "pend_complete", words_dispatched, 1);

    // Full random batch.
    do_reset();
    n = 0;
    while (m_acc < TOTAL && n < 20000) begin
      tick();
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = $urandom_range(0, 65535);
      lane_ready = N'($urandom_range(0, 15));
      n++;
    end
    check(n < 20000, "stream_fill_timeout", n, 20000);
    tick(); in_valid = 0;
    n = 0;
    while ((exp_q.size() != 0 || lane_valid != '0) && n < 20000) begin
      lane_ready = N'($urandom_range(0, 15));
      tick();
      n++;
    end
    check(n < 20000, "stream_drain_timeout", n, 20000);
    lane_ready = 4'b1111;
    tick();
    check(done == 1'b1, "batch_done", done, 1);
    check(words_dispatched == TOTAL, "batch_dispatched", words_dispatched, TOTAL);
    check(sum_push == sum_disp, "batch_sum", sum_disp, sum_push);
    in_valid = 1; in_data = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      tick();
      check(in_ready == 1'b0, "post_batch_ready", in_ready, 0);
    end
    in_valid = 0;

    // Asynchronous reset with words buffered and an offer active.
    do_reset();
    lane_ready = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      tick(); in_valid = 1; in_data = $urandom;
    end
    tick(); in_valid = 0; lane_ready = 4'b0010;
    tick(); lane_ready = 4'b0000;
    check(lane_valid == 4'b0010, "pre_reset_offer", lane_valid, 2);
    @(posedge proc_clk);
    #3 reset = 0;
    #1;
    check(lane_valid == '0, "async_lane_valid", lane_valid, 0);
    check(words_accepted == 0 && words_dispatched == 0, "async_counters", words_accepted, 0);
    check(!done && !overflow, "async_flags", {done, overflow}, 0);
    tick(); tick();
    reset = 1; lane_ready = 4'b1111; d = $urandom; in_valid = 1; in_data = d;
    tick(); in_valid = 0;
    tick(); check(lane_valid == 4'b0001 && lane_data == d, "post_reset_lane0", lane_valid, 1);
    wait_drain(20);

    // Only lane 3 ready: back-to-back dispatch with rr wrap.
    do_reset();
    lane_ready = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      tick(); in_valid = 1; in_data = $urandom;
    end
    tick(); in_valid = 0;
    check(words_dispatched == 6, "lane3_rate_a", words_dispatched, 6);
    tick(); check(words_dispatched == 7, "lane3_rate_b", words_dispatched, 7);
    tick(); check(words_dispatched == 8, "lane3_rate_c", words_dispatched, 8);
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
